// File: rtl/slib_input_filter_mc.sv
// Multi-channel input filter: per-line synchroniser, saturating up/down
// debounce counter with shared runtime threshold, hysteretic level decision
// and registered rise/fall/any-edge pulses.
module slib_input_filter_mc #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CE,
    input  logic [CHANNELS-1:0] CH_EN,
    input  logic [CNT_W-1:0]    THRESH,
    input  logic [CHANNELS-1:0] D,
    output logic [CHANNELS-1:0] Q,
    output logic [CHANNELS-1:0] RISE,
    output logic [CHANNELS-1:0] FALL,
    output logic                ANY_EDGE
);

    localparam logic [CHANNELS-1:0] LVL_RST = {CHANNELS{RESET_VAL}};
    localparam logic [CNT_W-1:0]    CNT_RST = {CNT_W{RESET_VAL}};

    logic [CHANNELS-1:0] s;
    logic [CNT_W-1:0]    thr_c;
    logic [CNT_W-1:0]    cnt     [CHANNELS];
    logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] q_nxt;
    logic [CHANNELS-1:0] rise_nxt;
    logic [CHANNELS-1:0] fall_nxt;

    // A zero threshold would never let Q leave its rail; treat it as 1.
    assign thr_c = (THRESH == '0) ? CNT_W'(1) : THRESH;

    generate
        if (SYNC_STAGES > 0) begin : gen_sync
            logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

            // Input synchroniser chain, clocked every cycle regardless of CE.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                        sync_q[k] <= LVL_RST;
                    end
                end else begin
                    sync_q[0] <= D;
                    for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end else begin : gen_nosync
            assign s = D;
        end
    endgenerate

    // Next counter values, level decisions and edge pulses for every channel.
    always_comb begin
        logic lvl;
        lvl      = 1'b0;
        q_nxt    = Q;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_nxt[i] = cnt[i];
            lvl        = Q[i];
            if (CH_EN[i]) begin
                // Counter moves only on a CE sample; clamp handles a lowered
                // threshold and the all-ones reset value.
                if (CE) begin
                    if (cnt[i] > thr_c) begin
                        cnt_nxt[i] = thr_c;
                    end else if (s[i] && (cnt[i] < thr_c)) begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end else if (!s[i] && (cnt[i] != '0)) begin
                        cnt_nxt[i] = cnt[i] - CNT_W'(1);
                    end
                end
                // Hysteresis: switch only at the rails, hold in between.
                if (cnt[i] >= thr_c) begin
                    lvl = 1'b1;
                end else if (cnt[i] == '0) begin
                    lvl = 1'b0;
                end
                q_nxt[i]    = lvl;
                rise_nxt[i] = lvl & ~Q[i];
                fall_nxt[i] = ~lvl & Q[i];
            end
        end
    end

    // Counter, level and pulse registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt[i] <= CNT_RST;
            end
            Q        <= LVL_RST;
            RISE     <= '0;
            FALL     <= '0;
            ANY_EDGE <= 1'b0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            Q        <= q_nxt;
            RISE     <= rise_nxt;
            FALL     <= fall_nxt;
            ANY_EDGE <= |(RISE | FALL);
        end
    end

endmodule

// File: tb/tb_slib_input_filter_mc.sv
// Self-checking bench for slib_input_filter_mc: directed scenarios plus a
// randomized run against a behavioural model of the filtering rules.
module tb_slib_input_filter_mc;

    localparam int CH   = 4;
    localparam int CW   = 4;
    localparam int SYNC = 2;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          rst1_n = 1'b0;
    logic          ce     = 1'b0;
    logic [CH-1:0] ch_en  = '1;
    logic [CW-1:0] thresh = 4'd4;
    logic [CH-1:0] d      = '0;

    logic [CH-1:0] q0, rise0, fall0, q1, rise1, fall1;
    logic          any0, any1;

    int checks   = 0;
    int failures = 0;

    // Reference model state (instance with RESET_VAL=0)
    int            mcnt [CH];
    logic [CH-1:0] mq, mrise, mfall;
    logic          many;
    logic [CH-1:0] dq [$];
    int            m_thr;
    logic [CH-1:0] m_s;
    logic          m_nq;

    slib_input_filter_mc #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SYNC), .RESET_VAL(1'b0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .CH_EN(ch_en), .THRESH(thresh), .D(d),
        .Q(q0), .RISE(rise0), .FALL(fall0), .ANY_EDGE(any0)
    );

    slib_input_filter_mc #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SYNC), .RESET_VAL(1'b1)) dut1 (
        .CLK(clk), .RST_N(rst1_n), .CE(ce), .CH_EN(ch_en), .THRESH(thresh), .D(d),
        .Q(q1), .RISE(rise1), .FALL(fall1), .ANY_EDGE(any1)
    );

    always #5 clk = ~clk;

    // Behavioural model: D seen SYNC edges later, counter as a clamped integer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) mcnt[c] = 0;
            mq = '0; mrise = '0; mfall = '0; many = 1'b0;
            dq.delete();
            for (int k = 0; k < SYNC; k++) dq.push_back('0);
        end else begin
            m_thr = (thresh == 0) ? 1 : int'(thresh);
            m_s   = (SYNC == 0) ? d : dq[0];
            many  = |(mrise | mfall);
            for (int c = 0; c < CH; c++) begin
                if (ch_en[c]) begin
                    m_nq = (mcnt[c] >= m_thr) ? 1'b1 : (mcnt[c] == 0) ? 1'b0 : mq[c];
                    mrise[c] = m_nq & ~mq[c];
                    mfall[c] = ~m_nq & mq[c];
                    mq[c]    = m_nq;
                    if (ce) begin
                        if (mcnt[c] > m_thr)  mcnt[c] = m_thr;
                        else if (m_s[c])      mcnt[c] = (mcnt[c] + 1 > m_thr) ? m_thr : mcnt[c] + 1;
                        else                  mcnt[c] = (mcnt[c] - 1 < 0) ? 0 : mcnt[c] - 1;
                    end
                end else begin
                    mrise[c] = 1'b0;
                    mfall[c] = 1'b0;
                end
            end
            dq.push_back(d);
            void'(dq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset0();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        d = '0; ce = 1'b0; ch_en = '1; thresh = 4'd4;
        rst_n = 1'b0; rst1_n = 1'b0;
        tick(); tick();
        checks++; if (q0 !== 4'h0) begin failures++; $display("FAIL reset_q0 got=%h exp=0", q0); end
        checks++; if ({rise0, fall0, any0} !== 9'h0) begin failures++; $display("FAIL reset_pulses0 got=%h exp=0", {rise0, fall0, any0}); end
        checks++; if (q1 !== 4'hF) begin failures++; $display("FAIL reset_q1 got=%h exp=f", q1); end
        checks++; if ({rise1, fall1, any1} !== 9'h0) begin failures++; $display("FAIL reset_pulses1 got=%h exp=0", {rise1, fall1, any1}); end
        rst_n = 1'b1; rst1_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        d = '0; ce = 1'b1; ch_en = '1; thresh = 4'd4;
        reset0();
        tick();
        d = 4'b0001;
        for (int k = 0; k <= 8; k++) begin
            tick();
            checks++; if (q0[0] !== (k >= 6)) begin failures++; $display("FAIL lat_rise_q edge=%0d got=%b exp=%b", k, q0[0], k >= 6); end
            checks++; if (rise0[0] !== (k == 6)) begin failures++; $display("FAIL lat_rise_pulse edge=%0d got=%b exp=%b", k, rise0[0], k == 6); end
            checks++; if (any0 !== (k == 7)) begin failures++; $display("FAIL lat_rise_any edge=%0d got=%b exp=%b", k, any0, k == 7); end
            checks++; if (q0[3:1] !== 3'b000) begin failures++; $display("FAIL lat_other_q edge=%0d got=%b exp=000", k, q0[3:1]); end
        end
        d = 4'b0000;
        for (int k = 0; k <= 8; k++) begin
            tick();
            checks++; if (q0[0] !== (k < 6)) begin failures++; $display("FAIL lat_fall_q edge=%0d got=%b exp=%b", k, q0[0], k < 6); end
            checks++; if (fall0[0] !== (k == 6)) begin failures++; $display("FAIL lat_fall_pulse edge=%0d got=%b exp=%b", k, fall0[0], k == 6); end
            checks++; if (any0 !== (k == 7)) begin failures++; $display("FAIL lat_fall_any edge=%0d got=%b exp=%b", k, any0, k == 7); end
        end
    endtask

    task automatic test_glitch();
        int rises;
        thresh = 4'd4; ce = 1'b1; ch_en = '1; d = '0;
        d[1] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        d[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (q0[1] !== 1'b0 || rise0[1] !== 1'b0) begin failures++; $display("FAIL glitch_q k=%0d got=%b/%b exp=0/0", k, q0[1], rise0[1]); end
        end
        checks++; if (dut0.cnt[1] !== 4'd0) begin failures++; $display("FAIL glitch_cnt got=%0d exp=0", dut0.cnt[1]); end
        rises = 0;
        d[1] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 4) d[1] = 1'b0;
            tick();
            if (rise0[1]) rises++;
            checks++; if (q0 !== mq) begin failures++; $display("FAIL glitch_model_q k=%0d got=%h exp=%h", k, q0, mq); end
        end
        checks++; if (rises != 1) begin failures++; $display("FAIL glitch_accept_rises got=%0d exp=1", rises); end
    endtask

    task automatic test_ce_strobe();
        logic ce_at [80];
        int   ticks, exp_edge, falls, fall_edge;
        thresh = 4'd3; ce = 1'b1; ch_en = '1; d = 4'b0100;
        for (int k = 0; k < 10; k++) tick();
        checks++; if (q0[2] !== 1'b1) begin failures++; $display("FAIL ce_pre_q got=%b exp=1", q0[2]); end
        d[2] = 1'b0;
        ticks = 0; exp_edge = -1; falls = 0; fall_edge = -1;
        for (int k = 0; k < 80; k++) begin
            ce = ((k % 16) == 5);
            ce_at[k] = ce;
            if (ce && k >= SYNC && exp_edge < 0) begin
                ticks++;
                if (ticks == 3) exp_edge = k + 1;
            end
            tick();
            if (fall0[2]) begin falls++; fall_edge = k; end
            checks++; if (fall0 !== mfall) begin failures++; $display("FAIL ce_model_fall k=%0d got=%h exp=%h", k, fall0, mfall); end
        end
        checks++; if (falls != 1) begin failures++; $display("FAIL ce_fall_count got=%0d exp=1", falls); end
        checks++; if (fall_edge != exp_edge) begin failures++; $display("FAIL ce_fall_edge got=%0d exp=%0d", fall_edge, exp_edge); end
        checks++; if (q0[2] !== 1'b0) begin failures++; $display("FAIL ce_post_q got=%b exp=0", q0[2]); end
    endtask

    task automatic test_clamp();
        thresh = 4'd10; ce = 1'b1; ch_en = '1; d = '1;
        for (int k = 0; k < 16; k++) tick();
        checks++; if (dut0.cnt[0] !== 4'd10 || q0 !== 4'hF) begin failures++; $display("FAIL clamp_pre cnt=%0d q=%h exp=10/f", dut0.cnt[0], q0); end
        ce = 1'b0; thresh = 4'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (dut0.cnt[0] !== 4'd10 || q0 !== 4'hF || rise0 !== 4'h0 || fall0 !== 4'h0) begin
                failures++; $display("FAIL clamp_hold cnt=%0d q=%h r=%h f=%h exp=10/f/0/0", dut0.cnt[0], q0, rise0, fall0); end
        end
        ce = 1'b1;
        tick();
        checks++; if (dut0.cnt[0] !== 4'd2 || q0 !== 4'hF || rise0 !== 4'h0 || fall0 !== 4'h0) begin
            failures++; $display("FAIL clamp_apply cnt=%0d q=%h r=%h f=%h exp=2/f/0/0", dut0.cnt[0], q0, rise0, fall0); end
        thresh = 4'd0;
        tick();
        checks++; if (dut0.cnt[0] !== 4'd1) begin failures++; $display("FAIL clamp_zero cnt=%0d exp=1", dut0.cnt[0]); end
        d[0] = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            tick();
            checks++; if (fall0[0] !== (k == 3)) begin failures++; $display("FAIL thr0_fall edge=%0d got=%b exp=%b", k, fall0[0], k == 3); end
            checks++; if (q0 !== mq) begin failures++; $display("FAIL thr0_model_q edge=%0d got=%h exp=%h", k, q0, mq); end
        end
    endtask

    task automatic test_ch_en();
        thresh = 4'd4; ce = 1'b1; ch_en = '1; d = '1;
        for (int k = 0; k < 10; k++) tick();
        checks++; if (q0 !== 4'hF) begin failures++; $display("FAIL chen_pre_q got=%h exp=f", q0); end
        ch_en = 4'b0111;
        for (int k = 0; k < 20; k++) begin
            d[3] = 1'($urandom);
            tick();
            checks++; if (q0[3] !== 1'b1 || dut0.cnt[3] !== 4'd4 || rise0[3] !== 1'b0 || fall0[3] !== 1'b0) begin
                failures++; $display("FAIL chen_frozen k=%0d q=%b cnt=%0d r=%b f=%b exp=1/4/0/0", k, q0[3], dut0.cnt[3], rise0[3], fall0[3]); end
        end
        d[3] = 1'b0; ch_en = '1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (q0 !== mq || fall0 !== mfall) begin failures++; $display("FAIL chen_resume k=%0d q=%h f=%h exp=%h/%h", k, q0, fall0, mq, mfall); end
        end
        checks++; if (q0[3] !== 1'b0) begin failures++; $display("FAIL chen_post_q got=%b exp=0", q0[3]); end
    endtask

    task automatic test_random();
        d = '0; ce = 1'b1; ch_en = '1; thresh = 4'd4;
        reset0();
        for (int k = 0; k < 3000; k++) begin
            if ((k % 250) == 0) thresh = 4'($urandom_range(0, 15));
            ce = 1'($urandom_range(0, 1));
            ch_en = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            for (int c = 0; c < CH; c++) if ($urandom_range(0, 7) == 0) d[c] = ~d[c];
            tick();
            checks++; if (q0 !== mq) begin failures++; $display("FAIL rnd_q k=%0d got=%h exp=%h", k, q0, mq); end
            checks++; if (rise0 !== mrise) begin failures++; $display("FAIL rnd_rise k=%0d got=%h exp=%h", k, rise0, mrise); end
            checks++; if (fall0 !== mfall) begin failures++; $display("FAIL rnd_fall k=%0d got=%h exp=%h", k, fall0, mfall); end
            checks++; if (any0 !== many) begin failures++; $display("FAIL rnd_any k=%0d got=%b exp=%b", k, any0, many); end
        end
    endtask

    task automatic test_reset_val1();
        thresh = 4'd4; ce = 1'b1; ch_en = '1; d = '1;
        for (int k = 0; k < 10; k++) tick();
        checks++; if (q1 !== 4'hF) begin failures++; $display("FAIL rv1_pre_q got=%h exp=f", q1); end
        d = '0;
        for (int k = 0; k < 3; k++) tick();
        #2 rst1_n = 1'b0;
        #1;
        checks++; if (q1 !== 4'hF) begin failures++; $display("FAIL rv1_async_q got=%h exp=f", q1); end
        checks++; if ({rise1, fall1, any1} !== 9'h0) begin failures++; $display("FAIL rv1_async_pulses got=%h exp=0", {rise1, fall1, any1}); end
        checks++; if (dut1.cnt[0] !== 4'hF) begin failures++; $display("FAIL rv1_async_cnt got=%0d exp=15", dut1.cnt[0]); end
        d = '1;
        tick(); tick();
        rst1_n = 1'b1;
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (q1 !== 4'hF || rise1 !== 4'h0 || fall1 !== 4'h0 || dut1.cnt[0] !== 4'hF) begin
                failures++; $display("FAIL rv1_release k=%0d q=%h r=%h f=%h cnt=%0d exp=f/0/0/15", k, q1, rise1, fall1, dut1.cnt[0]); end
        end
        ce = 1'b1;
        tick();
        checks++; if (dut1.cnt[0] !== 4'd4) begin failures++; $display("FAIL rv1_clamp got=%0d exp=4", dut1.cnt[0]); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (q1 !== 4'hF || rise1 !== 4'h0 || fall1 !== 4'h0 || any1 !== 1'b0) begin
                failures++; $display("FAIL rv1_quiet k=%0d q=%h r=%h f=%h a=%b exp=f/0/0/0", k, q1, rise1, fall1, any1); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_ce_strobe();
        test_clamp();
        test_ch_en();
        test_random();
        test_reset_val1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
